// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-timer game sequencer: state codes,
// LFSR constants and the initial best-score value.
package reaction_pkg;

  // Codes 6..15 are unused; the sequencer recovers from them to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WAIT   = 4'd1,
    ST_TIMING = 4'd2,
    ST_RESULT = 4'd3,
    ST_FAULT  = 4'd4,
    ST_SETTLE = 4'd5
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [11:0] BEST_INIT = 12'h999;

  // One step of the 16-bit Galois LFSR (shift right, fold taps on bit 0).
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Board-key / timing-datapath / display signals of the reaction game.
// slave: the sequencer. master: keys, timing datapath and display side.
interface reaction_game_ctrl_if;
  logic [1:0] KEY;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [3:0] score_c;
  logic       timer_en;
  logic [3:0] out_state;
  logic       false_start;
  logic       timeout;
  logic [3:0] best_a;
  logic [3:0] best_b;
  logic [3:0] best_c;
  logic       new_best;

  modport master (
    output KEY, score_a, score_b, score_c,
    input  timer_en, out_state, false_start, timeout,
    input  best_a, best_b, best_c, new_best
  );

  modport slave (
    input  KEY, score_a, score_b, score_c,
    output timer_en, out_state, false_start, timeout,
    output best_a, best_b, best_c, new_best
  );
endinterface

// File: rtl/reaction_game_ctrl_ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every TICK_DIV clocks.
// clr restarts the period so the first tick lands TICK_DIV clocks later.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Period counter, wraps on the tick and restarts on clr.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: arms a random pre-delay, enables the BCD
// timing datapath, detects reaction / false start / timeout and keeps the
// best score. Optional feature macro: BEST_SCORE_EN (best-score tracking;
// when undefined best_* and new_best are tied to 0).
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int TIMEOUT_MS  = 999
) (
  input logic               clk,
  input logic               rst,
  reaction_game_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS));
  localparam int MS_W   = $clog2(TIMEOUT_MS + 1);

  state_e            state, state_next;
  logic [1:0]        key_meta, key_sync, key_prev;
  logic              react_press, start_press;
  logic [15:0]       lfsr;
  logic              tick, entering;
  logic [WAIT_W-1:0] wait_cnt, wait_load;
  logic [MS_W-1:0]   ms_cnt;
  logic              settle_cnt;
  logic              timeout_q;

  // Key synchronizers plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk) begin
    // NOTE: these flops reset to the released (high) level so reset never fakes a press.
    if (rst) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
      key_prev <= 2'b11;
    end else begin
      key_meta <= bus.KEY;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign react_press = key_prev[0] & ~key_sync[0];
  assign start_press = key_prev[1] & ~key_sync[1];

  // Free-running pseudo-random source for the pre-delay.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign wait_load = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[RAND_BITS-1:0]);
  assign entering  = (state_next != state);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (entering),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; react beats both the pre-delay expiry and the timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (start_press) state_next = ST_WAIT;
      ST_WAIT: begin
        if (react_press)                            state_next = ST_FAULT;
        else if (tick && wait_cnt <= WAIT_W'(1))    state_next = ST_TIMING;
      end
      ST_TIMING: begin
        if (react_press)                            state_next = ST_SETTLE;
        else if (tick && ms_cnt == MS_W'(TIMEOUT_MS - 1)) state_next = ST_SETTLE;
      end
      ST_SETTLE: if (settle_cnt)  state_next = ST_RESULT;
      ST_RESULT: if (start_press) state_next = ST_WAIT;
      ST_FAULT:  if (start_press) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Round counters and the timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      ms_cnt     <= '0;
      settle_cnt <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (start_press && (state == ST_IDLE || state == ST_RESULT)) wait_cnt <= wait_load;
      else if (state == ST_WAIT && tick)                          wait_cnt <= wait_cnt - WAIT_W'(1);

      if (state != ST_TIMING) ms_cnt <= '0;
      else if (tick)          ms_cnt <= ms_cnt + MS_W'(1);

      settle_cnt <= (state == ST_SETTLE) ? ~settle_cnt : 1'b0;

      if (state == ST_TIMING && state_next == ST_SETTLE) timeout_q <= ~react_press;
      else if (state == ST_RESULT && start_press)        timeout_q <= 1'b0;
    end
  end

  assign bus.timer_en    = (state == ST_TIMING);
  assign bus.out_state   = state;
  assign bus.false_start = (state == ST_FAULT);
  assign bus.timeout     = timeout_q;

`ifdef BEST_SCORE_EN
  logic [11:0] best_q;
  logic [11:0] score_val;
  logic        new_best_q;

  assign score_val = {bus.score_c, bus.score_b, bus.score_a};

  // Best score: BCD digits compare correctly as one 12-bit unsigned value.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q     <= BEST_INIT;
      new_best_q <= 1'b0;
    end else if (state == ST_SETTLE && settle_cnt) begin
      if (!timeout_q && score_val < best_q) begin
        best_q     <= score_val;
        new_best_q <= 1'b1;
      end
    end else if (state == ST_RESULT && start_press) begin
      new_best_q <= 1'b0;
    end
  end

  assign bus.best_c   = best_q[11:8];
  assign bus.best_b   = best_q[7:4];
  assign bus.best_a   = best_q[3:0];
  assign bus.new_best = new_best_q;
`else
  logic score_unused;
  assign score_unused = ^{bus.score_c, bus.score_b, bus.score_a};

  assign bus.best_c   = 4'd0;
  assign bus.best_b   = 4'd0;
  assign bus.best_a   = 4'd0;
  assign bus.new_best = 1'b0;
`endif

endmodule
